pipelined_adder_tree: RTL and testbench
=======================================

PIPELINED_ADDER_TREE -- requirements
Module: pipelined_adder_tree

Interface
REQ-001 SHALL have parameter IN_W, default 20, width of each input operand.
REQ-002 SHALL have parameter N, default 8, operand count; power of two, N >= 2.
REQ-003 SHALL have parameter SIGNED, default 0; 0 = unsigned, 1 = two's-complement operands.
REQ-004 SHALL have parameter ACC_W, default 32, accumulator/output width; ACC_W >= IN_W + log2(N) (elaboration error otherwise).
REQ-005 SHALL use one clock and an asynchronous, active-low reset, with ports clk and rst_n.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 in_valid  input  1  in_data and in_last valid this cycle.
REQ-009 in_ready  output  1  block accepts a beat this cycle.
REQ-010 in_data  input  N*IN_W  packed operands; operand i = bits [(i+1)*IN_W-1 : i*IN_W].
REQ-011 in_last  input  1  final beat of the current frame.
REQ-012 out_valid  output  1  out_sum and out_ovf hold a completed frame result.
REQ-013 out_ready  input  1  consumer accepts the result.
REQ-014 out_sum  output  ACC_W  frame sum, modulo 2^ACC_W.
REQ-015 out_ovf  output  1  frame sum exceeded the ACC_W range.

Function
REQ-016 Beat transfer SHALL occur when in_valid && in_ready; result transfer when out_valid && out_ready.
REQ-017 Global enable en = !(out_valid && !out_ready); in_ready SHALL equal en (combinational).
REQ-018 The tree SHALL have L = log2(N) registered levels; level k (1..L) adds adjacent pairs of level k-1 at width IN_W+k, sign-extending operands when SIGNED=1 and zero-extending otherwise.
REQ-019 Each level SHALL carry a valid bit and a last bit alongside its sums; all levels advance only when en=1 and hold when en=0.
REQ-020 The accumulator stage SHALL, on a valid level-L output with en=1, compute acc_next = (first beat of frame ? 0 : acc) + extended tree sum, at ACC_W bits.
REQ-021 On a last beat, the accumulator stage SHALL load acc_next into out_sum, set out_valid=1, clear acc, and mark the next beat as first of frame.
REQ-022 Latency SHALL be L+1 cycles from acceptance of a last beat to out_valid=1 with no backpressure; throughput SHALL be one beat per cycle.
REQ-023 out_ovf SHALL be sticky within a frame: unsigned carry-out of any accumulate, or signed overflow (equal operand signs, different result sign); cleared at frame start.
REQ-024 out_valid SHALL clear when the result is taken and no new result is loaded in the same cycle; a simultaneous take and load SHALL keep out_valid=1 with the new values.
REQ-025 out_sum and out_ovf SHALL remain stable while out_valid && !out_ready.
REQ-026 Bubbles (in_valid=0) within a frame SHALL NOT disturb acc; frames of any beat count >= 1 SHALL be supported.

Reset
REQ-027 Asserting rst_n low SHALL immediately clear all level valid/last bits, acc, first flag (to 1), out_valid, out_sum, out_ovf, and all level sums to 0.
REQ-028 A reset mid-frame SHALL discard the partial frame; in_ready SHALL read 1 during and after reset.

Structure
REQ-029 Package adder_tree_pkg SHALL hold default parameter constants and a clog2 function.
REQ-030 A sub-module adder_tree_level SHALL implement one registered pair-add level (parameters: pair count, input width, SIGNED), instantiated L times via generate.

Verification (N=8, IN_W=20, ACC_W=32 unless stated)
REQ-031 Single-beat frame, all operands 1, in_last=1 -> out_sum=8, out_ovf=0, out_valid rises 4 cycles after acceptance.
REQ-032 Three-beat frame, all operands 0xFFFFF, SIGNED=0 -> out_sum=25165800, out_ovf=0.
REQ-033 SIGNED=1, single beat, all operands 0xFFFFF (-1) -> out_sum=0xFFFFFFF8 (-8), out_ovf=0.
REQ-034 ACC_W=24, SIGNED=0, three beats of all 0xFFFFF -> out_sum=8388584, out_ovf=1; two beats -> 16777200, out_ovf=0.
REQ-035 Back-to-back single-beat frames (values 1,2,3 per operand) with out_ready low 5 cycles -> in_ready low while stalled, results 8,16,24 delivered in order, none lost or duplicated.
REQ-036 rst_n pulsed low after two non-last beats -> out_valid=0, out_sum=0; following single-beat frame of all 1 -> out_sum=8.

Source files
------------

// File: rtl/adder_tree_pkg.sv
// Shared defaults and elaboration helpers for the pipelined adder tree.
package adder_tree_pkg;

  localparam int DEF_IN_W   = 20;
  localparam int DEF_N      = 8;
  localparam int DEF_SIGNED = 0;
  localparam int DEF_ACC_W  = 32;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One registered level of the adder tree: PAIRS adjacent operand pairs summed at IN_W+1 bits.
module adder_tree_level
  import adder_tree_pkg::*;
#(
  parameter int PAIRS  = 4,
  parameter int IN_W   = 20,
  parameter int SIGNED = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      in_valid,
  input  logic                      in_last,
  input  logic [2*PAIRS*IN_W-1:0]   in_data,
  output logic                      out_valid,
  output logic                      out_last,
  output logic [PAIRS*(IN_W+1)-1:0] out_data
);

  localparam int OW = IN_W + 1;

  logic [PAIRS*OW-1:0] sum_d;

  function automatic logic [OW-1:0] ext(input logic [IN_W-1:0] v);
    ext = {((SIGNED != 0) ? v[IN_W-1] : 1'b0), v};
  endfunction

  always_comb begin
    sum_d = '0;
    for (int p = 0; p < PAIRS; p++) begin
      sum_d[p*OW +: OW] = ext(in_data[2*p*IN_W +: IN_W]) + ext(in_data[(2*p+1)*IN_W +: IN_W]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      out_last  <= in_last;
      out_data  <= sum_d;
    end
  end

endmodule

// File: rtl/pipelined_adder_tree.sv
// Pipelined N-operand adder tree feeding a per-frame accumulator with sticky overflow.
module pipelined_adder_tree
  import adder_tree_pkg::*;
#(
  parameter int IN_W   = DEF_IN_W,
  parameter int N      = DEF_N,
  parameter int SIGNED = DEF_SIGNED,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N*IN_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf
);

  localparam int L  = clog2(N);
  localparam int TW = IN_W + L;

  if (N < 2 || (1 << L) != N) begin : g_bad_n
    $error("pipelined_adder_tree: N must be a power of two >= 2");
  end
  if (ACC_W < TW) begin : g_bad_acc_w
    $error("pipelined_adder_tree: ACC_W must be >= IN_W + log2(N)");
  end

  // Handshake: a beat moves when in_valid && in_ready, a result when out_valid && out_ready.
  // The whole pipeline stalls only when a finished result is waiting and not being taken.
  logic en;
  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;

  logic [L:0] lvl_valid;
  logic [L:0] lvl_last;
  assign lvl_valid[0] = in_valid;
  assign lvl_last[0]  = in_last;

  genvar k;
  for (k = 1; k <= L; k++) begin : g_level
    localparam int WI    = IN_W + k - 1;
    localparam int PAIRS = N >> k;

    logic [2*PAIRS*WI-1:0]   lvl_in;
    logic [PAIRS*(WI+1)-1:0] lvl_sum;

    if (k == 1) begin : g_first
      assign lvl_in = in_data;
    end else begin : g_next
      assign lvl_in = g_level[k-1].lvl_sum;
    end

    adder_tree_level #(
      .PAIRS (PAIRS),
      .IN_W  (WI),
      .SIGNED(SIGNED)
    ) u_level (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .in_valid (lvl_valid[k-1]),
      .in_last  (lvl_last[k-1]),
      .in_data  (lvl_in),
      .out_valid(lvl_valid[k]),
      .out_last (lvl_last[k]),
      .out_data (lvl_sum)
    );
  end

  logic [TW-1:0]    tree_sum;
  logic [ACC_W-1:0] tree_ext;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] base;
  logic [ACC_W-1:0] acc_next;
  logic             carry;
  logic             signed_ovf;
  logic             ovf_acc;
  logic             ovf_next;
  logic             first;

  assign tree_sum = g_level[L].lvl_sum;

  always_comb begin
    tree_ext = ACC_W'(tree_sum);
    if (SIGNED != 0) tree_ext = ACC_W'($signed(tree_sum));
    base               = first ? '0 : acc;
    {carry, acc_next}  = {1'b0, base} + {1'b0, tree_ext};
    // Two's-complement overflow: operands agree in sign, result disagrees.
    signed_ovf = (base[ACC_W-1] == tree_ext[ACC_W-1]) && (acc_next[ACC_W-1] != base[ACC_W-1]);
    ovf_next   = (first ? 1'b0 : ovf_acc) | ((SIGNED != 0) ? signed_ovf : carry);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      ovf_acc   <= 1'b0;
      first     <= 1'b1;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
    end else if (en) begin
      if (lvl_valid[L] && lvl_last[L]) begin
        out_sum   <= acc_next;
        out_ovf   <= ovf_next;
        out_valid <= 1'b1;
        acc       <= '0;
        ovf_acc   <= 1'b0;
        first     <= 1'b1;
      end else begin
        // Either nothing was pending or the pending result was just taken.
        out_valid <= 1'b0;
        if (lvl_valid[L]) begin
          acc     <= acc_next;
          ovf_acc <= ovf_next;
          first   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_adder_tree.sv
// Directed bench: three tree instances (unsigned/32, signed/32, unsigned/24) share one input stream.
module tb_pipelined_adder_tree;

  localparam int IN_W = 20;
  localparam int N    = 8;
  localparam int EW   = 91;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic [N*IN_W-1:0] in_data;
  logic              in_last;
  logic              out_ready;
  logic              in_ready_u, in_ready_s, in_ready_n;
  logic              out_valid_u, out_valid_s, out_valid_n;
  logic [31:0]       out_sum_u, out_sum_s;
  logic [23:0]       out_sum_n;
  logic              out_ovf_u, out_ovf_s, out_ovf_n;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;

  typedef struct {
    logic [19:0] val;
    int          beats;
    logic        bubbles;
    logic [31:0] sum_u;
    logic        ovf_u;
    logic [31:0] sum_s;
    logic        ovf_s;
    logic [23:0] sum_n;
    logic        ovf_n;
  } vec_t;

  vec_t vecs[9];

  pipelined_adder_tree #(.IN_W(IN_W), .N(N), .SIGNED(0), .ACC_W(32)) dut_u (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_u),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid_u),
    .out_ready(out_ready), .out_sum(out_sum_u), .out_ovf(out_ovf_u)
  );

  pipelined_adder_tree #(.IN_W(IN_W), .N(N), .SIGNED(1), .ACC_W(32)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid_s),
    .out_ready(out_ready), .out_sum(out_sum_s), .out_ovf(out_ovf_s)
  );

  pipelined_adder_tree #(.IN_W(IN_W), .N(N), .SIGNED(0), .ACC_W(24)) dut_n (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_n),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid_n),
    .out_ready(out_ready), .out_sum(out_sum_n), .out_ovf(out_ovf_n)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] su, input logic ou, input logic [31:0] ss,
                          input logic os, input logic [23:0] sn, input logic on);
    exp_q.push_back({su, ou, ss, os, sn, on});
  endtask

  // Scoreboard: every transferred result is compared against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid_u && out_ready) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_result: got sum %0h, expected no result", out_sum_u);
      end else begin
        mon_e = exp_q.pop_front();
        check("sum_u", out_sum_u, mon_e[90:59]);
        check("ovf_u", 32'(out_ovf_u), 32'(mon_e[58]));
        check("valid_s", 32'(out_valid_s), 32'd1);
        check("sum_s", out_sum_s, mon_e[57:26]);
        check("ovf_s", 32'(out_ovf_s), 32'(mon_e[25]));
        check("valid_n", 32'(out_valid_n), 32'd1);
        check("sum_n", 32'(out_sum_n), 32'(mon_e[24:1]));
        check("ovf_n", 32'(out_ovf_n), 32'(mon_e[0]));
      end
    end
  end

  // Driver tasks: inputs change 1 ns after the rising edge.
  task automatic send_beat(input logic [19:0] val, input logic last);
    int t;
    in_valid = 1'b1;
    in_data  = {N{val}};
    in_last  = last;
    t = 0;
    while (!in_ready_u && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!in_ready_u) begin
      tests_run++;
      tests_failed++;
      $display("FAIL beat_accept: got in_ready 0, expected 1 within 100 cycles");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_frame(input logic [19:0] val, input int beats, input logic bubbles);
    for (int b = 0; b < beats; b++) begin
      if (bubbles && $urandom_range(0, 1) == 1) idle_cycles(int'($urandom_range(1, 3)));
      send_beat(val, b == beats - 1);
    end
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int cnt;

    vecs[0] = '{20'h00001,   1, 1'b0, 32'd8,          1'b0, 32'd8,          1'b0, 24'd8,       1'b0};
    vecs[1] = '{20'hFFFFF,   3, 1'b0, 32'd25165800,   1'b0, 32'hFFFFFFE8,   1'b0, 24'd8388584, 1'b1};
    vecs[2] = '{20'hFFFFF,   1, 1'b0, 32'd8388600,    1'b0, 32'hFFFFFFF8,   1'b0, 24'd8388600, 1'b0};
    vecs[3] = '{20'hFFFFF,   2, 1'b1, 32'd16777200,   1'b0, 32'hFFFFFFF0,   1'b0, 24'd16777200, 1'b0};
    vecs[4] = '{20'h7FFFF,   5, 1'b1, 32'd20971480,   1'b0, 32'd20971480,   1'b0, 24'd4194264, 1'b1};
    vecs[5] = '{20'h80000,   2, 1'b0, 32'd8388608,    1'b0, 32'hFF800000,   1'b0, 24'd8388608, 1'b0};
    vecs[6] = '{20'h00002,   3, 1'b1, 32'd48,         1'b0, 32'd48,         1'b0, 24'd48,      1'b0};
    vecs[7] = '{20'h7FFFF, 513, 1'b0, 32'h803FEFF8,   1'b0, 32'h803FEFF8,   1'b1, 24'h3FEFF8,  1'b1};
    vecs[8] = '{20'h00003,   1, 1'b0, 32'd24,         1'b0, 32'd24,         1'b0, 24'd24,      1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #12;
    check("reset_out_valid", 32'(out_valid_u), 32'd0);
    check("reset_out_sum", out_sum_u, 32'd0);
    check("reset_out_ovf", 32'(out_ovf_u), 32'd0);
    check("reset_in_ready", 32'(in_ready_u), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_cycles(2);

    // Latency of a single-beat frame, counting the acceptance edge as cycle 1.
    push_exp(32'd8, 1'b0, 32'd8, 1'b0, 24'd8, 1'b0);
    in_valid = 1'b1;
    in_data  = {N{20'h00001}};
    in_last  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    cnt = 1;
    while (!out_valid_u && cnt < 20) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("latency", 32'(cnt), 32'd4);
    drain("drain_latency");

    // Table-driven frames with hand-computed sums.
    for (int v = 0; v < 9; v++) begin
      push_exp(vecs[v].sum_u, vecs[v].ovf_u, vecs[v].sum_s, vecs[v].ovf_s,
               vecs[v].sum_n, vecs[v].ovf_n);
      run_frame(vecs[v].val, vecs[v].beats, vecs[v].bubbles);
    end
    drain("drain_vectors");

    // Back-to-back frames under a 5-cycle output stall.
    out_ready = 1'b0;
    push_exp(32'd8,  1'b0, 32'd8,  1'b0, 24'd8,  1'b0);
    push_exp(32'd16, 1'b0, 32'd16, 1'b0, 24'd16, 1'b0);
    push_exp(32'd24, 1'b0, 32'd24, 1'b0, 24'd24, 1'b0);
    send_beat(20'h00001, 1'b1);
    send_beat(20'h00002, 1'b1);
    send_beat(20'h00003, 1'b1);
    cnt = 0;
    while (!out_valid_u && cnt < 20) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("stall_out_valid", 32'(out_valid_u), 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("stall_in_ready", 32'(in_ready_u), 32'd0);
      check("stall_sum_stable", out_sum_u, 32'd8);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    drain("drain_stall");
    idle_cycles(3);
    check("stall_no_duplicate", 32'(out_valid_u), 32'd0);

    // Reset in the middle of a frame discards the partial sum.
    send_beat(20'h00001, 1'b0);
    send_beat(20'h00001, 1'b0);
    rst_n = 1'b0;
    #2;
    check("midreset_out_valid", 32'(out_valid_u), 32'd0);
    check("midreset_out_sum", out_sum_u, 32'd0);
    check("midreset_in_ready", 32'(in_ready_u), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("postreset_in_ready", 32'(in_ready_u), 32'd1);
    push_exp(32'd8, 1'b0, 32'd8, 1'b0, 24'd8, 1'b0);
    run_frame(20'h00001, 1, 1'b0);
    drain("drain_reset");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
